// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 32 x 32 MIPS32 general-purpose register file
//
// Purpose
//   Serves the decode stage: two combinational read ports and one synchronous
//   write port fed from write-back. Register 0 is hardwired to zero. The
//   storage array has no reset so it can map to LUTRAM. After reset, a clear
//   sequencer writes zero to every entry. A debug dump engine streams all
//   registers, one per beat, over a valid/ready port.
//
// Optional feature (macro REGFILE_BYPASS_EN)
//   When defined, a read whose index matches the write in the same cycle
//   returns the incoming wdata (write-first). Dump beats use the same bypass.
//   When undefined, reads return the array contents from before the write.
//
// Ports
//   clk, rst            clock (rising edge); synchronous active-high reset
//   we, waddr, wdata    write port (write-back)
//   re1, raddr1, rdata1 read port 1 (combinational data)
//   re2, raddr2, rdata2 read port 2 (combinational data)
//   init_done           high once the post-reset clear has finished
//   dbg_start           one-cycle pulse that starts a dump (ignored unless idle)
//   dbg_valid/dbg_ready dump beat handshake
//   dbg_idx, dbg_data   index and value of the current beat
//   dbg_last            current beat is the final register
//   dbg_busy            dump in progress
//
// Handshake: a dump beat transfers on a rising edge where dbg_valid and
// dbg_ready are both high. While dbg_valid is high and dbg_ready is low,
// dbg_idx stays fixed. dbg_data is the live array value at that index, so it
// only changes if write-back writes that register.
// ---------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_done,
  input  logic              dbg_start,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_last,
  output logic              dbg_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_CLR = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DUMP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] dbg_idx_q, dbg_idx_d;

  // Entry 0 is never written and never read; it exists only so that the
  // array can be indexed directly by a register number.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic              wb_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              hit1;
  logic              hit2;
  logic              hit_dbg;

  // -------------------------------------------------------------------------
  // Control FSM: next state and sequencer counters
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    dbg_idx_d = dbg_idx_q;
    clr_we    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // One entry is zeroed per edge, starting at 1 (entry 0 is unused).
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + FIRST_CLR;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = FIRST_CLR;
        end
      end

      ST_IDLE: begin
        dbg_idx_d = '0;
        if (dbg_start) begin
          state_d = ST_DUMP;
        end
      end

      ST_DUMP: begin
        if (dbg_ready) begin
          if (dbg_idx_q == LAST_IDX) begin
            state_d   = ST_IDLE;
            dbg_idx_d = '0;
          end else begin
            dbg_idx_d = dbg_idx_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = FIRST_CLR;
        dbg_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= FIRST_CLR;
      dbg_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      dbg_idx_q <= dbg_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    init_done = (state_q == ST_IDLE) || (state_q == ST_DUMP);
    dbg_valid = (state_q == ST_DUMP);
    dbg_busy  = (state_q == ST_DUMP);
    dbg_idx   = dbg_idx_q;
    dbg_last  = dbg_valid && (dbg_idx_q == LAST_IDX);
  end

  // -------------------------------------------------------------------------
  // Array write port. The clear sequencer and write-back never compete:
  // write-back is only accepted once init_done is high, which is never true
  // in CLEAR. A cycle with rst high writes nothing because the clear that
  // follows rewrites the whole array.
  // -------------------------------------------------------------------------
  always_comb begin
    wb_we     = we && init_done && (waddr != '0);
    mem_we    = !rst && (clr_we || wb_we);
    mem_waddr = clr_we ? clr_idx_q : waddr;
    mem_wdata = clr_we ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Write-first bypass detection
  // -------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    hit1    = wb_we && (waddr == raddr1);
    hit2    = wb_we && (waddr == raddr2);
    hit_dbg = wb_we && (waddr == dbg_idx_q);
  end
`else
  always_comb begin
    hit1    = 1'b0;
    hit2    = 1'b0;
    hit_dbg = 1'b0;
  end
`endif

  // -------------------------------------------------------------------------
  // Read ports. The priority order matters: reset and an unfinished clear
  // mask the array, which may still hold stale or uninitialised contents.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata1 = '0;
    if (rst || !init_done || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (hit1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || !init_done || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (hit2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_q[raddr2];
    end
  end

  // Dump data is read live from the array. A write that lands before a
  // beat's handshake therefore shows up in that beat.
  always_comb begin
    dbg_data = '0;
    if (dbg_idx_q == '0) begin
      dbg_data = '0;
    end else if (hit_dbg) begin
      dbg_data = wdata;
    end else begin
      dbg_data = mem_q[dbg_idx_q];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile
//
// The driver applies inputs 1 time unit after each rising edge. Each time it
// issues a read, it pushes the expected data into a queue. When it starts a
// dump, it pushes the full list of expected beats. A monitor samples at the
// falling edge and compares DUT outputs against the front of these queues.
// The reference model is a plain array that follows the register-file rules.
// ---------------------------------------------------------------------------
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_done;
  logic        dbg_start;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic        dbg_last;
  logic        dbg_busy;

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .init_done (init_done),
    .dbg_start (dbg_start),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data),
    .dbg_last  (dbg_last),
    .dbg_busy  (dbg_busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [32];
  logic        ref_init = 1'b0;
  int          ref_cnt  = 0;

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp1_q [$];
  logic [31:0] exp2_q [$];
  logic [37:0] dbg_q  [$];   // {last, idx[4:0], data[31:0]}
  logic        rd_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // Expected read value from the register-file rules, given the inputs
  // currently applied.
  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !ref_init || !en || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return ref_mem[a];
  endfunction

  // One clock edge; the model is updated with the inputs held across it.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ref_init = 1'b0;
      ref_cnt  = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    end else if (!ref_init) begin
      ref_cnt++;
      if (ref_cnt == 31) ref_init = 1'b1;
    end else if (we && waddr != 5'd0) begin
      ref_mem[waddr] = wdata;
    end
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic issue_reads();
    exp1_q.push_back(exp_rd(re1, raddr1));
    exp2_q.push_back(exp_rd(re2, raddr2));
    rd_chk = 1'b1;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) begin
      logic [4:0]  ix;
      logic [31:0] d;
      ix = 5'(i);
      d  = (i == 0) ? 32'h0 : ref_mem[i];
      dbg_q.push_back({(i == 31), ix, d});
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    dbg_start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_chk) begin
      if (exp1_q.size() > 0) check("rdata1", rdata1, exp1_q.pop_front());
      if (exp2_q.size() > 0) check("rdata2", rdata2, exp2_q.pop_front());
    end
    if (dbg_valid === 1'b1) begin
      if (dbg_q.size() == 0) begin
        fail_event("dbg_unexpected_beat");
      end else begin
        logic [37:0] e;
        e = dbg_q[0];
        check("dbg_idx",  32'(dbg_idx),  32'(e[36:32]));
        check("dbg_data", dbg_data,      e[31:0]);
        check("dbg_last", 32'(dbg_last), 32'(e[37]));
        check("dbg_busy", 32'(dbg_busy), 32'h1);
        if (dbg_ready) begin
          void'(dbg_q.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int budget;
    rst = 1'b1;
    dbg_ready = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    // Reset state
    step();
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_dbg_valid", 32'(dbg_valid), 32'h0);
    check("rst_dbg_busy",  32'(dbg_busy),  32'h0);
    check("rst_dbg_idx",   32'(dbg_idx),   32'h0);
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    issue_reads();
    step();

    // Clear timing: low for 30 edges, high after edge 31
    rst = 1'b0;
    idle_inputs();
    for (int e = 1; e <= 30; e++) begin
      step();
      if (init_done !== 1'b0) check("clear_early_done", 32'(init_done), 32'h0);
    end
    check("clear_edge30_done", 32'(init_done), 32'h0);
    step();
    check("clear_edge31_done", 32'(init_done), 32'h1);

    // Every index reads zero after the clear
    for (int i = 0; i < 32; i++) begin
      re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(31 - i);
      issue_reads();
      step();
    end

    // Basic write and read-enable masking
    idle_inputs();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    issue_reads();
    step();
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd5;
    issue_reads();
    step();
    re1 = 1'b0;
    issue_reads();
    step();

    // Zero register
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    step();
    idle_inputs();
    re2 = 1'b1; raddr2 = 5'd0;
    issue_reads();
    step();

    // Same-cycle read of a write
    idle_inputs();
    we = 1'b1; waddr = 5'd7; wdata = 32'h11;
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'h22; re1 = 1'b1; raddr1 = 5'd7;
    re2 = 1'b1; raddr2 = 5'd7;
    issue_reads();
    step();
    we = 1'b0;
    issue_reads();
    step();

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = 1'($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      re2    = 1'($urandom_range(0, 3) != 0);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      issue_reads();
      step();
    end

    // Dump with backpressure
    idle_inputs();
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    step();
    idle_inputs();
    check("model_r3", ref_mem[3], 32'h33);
    push_dump();
    beat_cnt  = 0;
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
    budget = 0;
    while (beat_cnt < 32 && budget < 200) begin
      dbg_ready = ~dbg_ready;
      step();
      budget++;
    end
    if (beat_cnt < 32) fail_event("dump_timeout");
    dbg_ready = 1'b0;
    check("dump_beats",       32'(beat_cnt),  32'd32);
    check("dump_end_valid",   32'(dbg_valid), 32'h0);
    check("dump_end_busy",    32'(dbg_busy),  32'h0);
    step();
    check("dump_idle_valid",  32'(dbg_valid), 32'h0);

    // Reset in the middle of a dump
    push_dump();
    beat_cnt  = 0;
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
    dbg_ready = 1'b1;
    budget = 0;
    while (beat_cnt < 10 && budget < 100) begin
      step();
      budget++;
    end
    if (beat_cnt < 10) fail_event("dump2_timeout");
    dbg_ready = 1'b0;
    rst = 1'b1;
    step();
    dbg_q.delete();
    check("mid_rst_dbg_valid", 32'(dbg_valid), 32'h0);
    check("mid_rst_init_done", 32'(init_done), 32'h0);
    check("mid_rst_dbg_busy",  32'(dbg_busy),  32'h0);
    rst = 1'b0;
    for (int e = 1; e <= 30; e++) step();
    check("reclear_edge30_done", 32'(init_done), 32'h0);
    step();
    check("reclear_edge31_done", 32'(init_done), 32'h1);
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd5;
    issue_reads();
    step();
    idle_inputs();
    step();

    check("rd_queue_drained", 32'(exp1_q.size() + exp2_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
